// File: rtl/nbit_demux_reg_pkg.sv
// Shared definitions for the bit-assembly demux and the control FSMs that
// reuse its fill-state encoding.
//   demux_state_e        : EMPTY / PARTIAL / FULL fill state of a word
//   DEFAULT_SELECT_WIDTH : default select width (word of 8 bits)
//   word_width()         : N = 2**select_width
package nbit_demux_reg_pkg;

  typedef enum logic [1:0] {
    ST_EMPTY   = 2'd0,
    ST_PARTIAL = 2'd1,
    ST_FULL    = 2'd2
  } demux_state_e;

  localparam int DEFAULT_SELECT_WIDTH = 3;

  function automatic int word_width(input int select_width);
    return 1 << select_width;
  endfunction

endpackage

// File: rtl/nbit_demux_reg_ptr_counter.sv
// Wrapping sequential-write pointer.
//   clk, rst_n : clock, asynchronous active-low reset
//   en         : advance by one (wraps from 2**W-1 to 0)
//   clr        : synchronous return to 0, overrides en
//   count      : current pointer value (registered)
module ptr_counter #(
  parameter int W = 3
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count
);

  logic [W-1:0] count_q;
  logic [W-1:0] count_d;

  always_comb begin
    count_d = count_q;
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      // Natural overflow of a W-bit add gives the modulo-N wrap.
      count_d = count_q + W'(1);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/nbit_demux_reg.sv
// Registered 1-to-N demultiplexer: assembles an N-bit word one bit at a time,
// either at an explicit index (wr_en/DemuxSel) or at an auto-advancing
// pointer (shift_en/ptr), and tracks which bits have been written.
//   clk, rst_n : clock, asynchronous active-low reset
//   DemuxIn    : data bit to deposit
//   DemuxSel   : target index for random-access writes
//   wr_en      : random-access write strobe
//   shift_en   : sequential write strobe (writes at ptr, then advances ptr)
//   clear      : synchronous clear of data, mask, pointer and state
//   DemuxOut   : assembled word
//   valid_mask : bit i set once bit i has been written
//   ptr        : sequential write pointer
//   full       : high while every bit has been written
//   done       : one-cycle pulse when the word first becomes full
//   dbg_state  : fill state (EMPTY/PARTIAL/FULL) for observation
//
// Handshake: strobes are plain single-cycle commands with no backpressure;
// each strobe high on a rising edge is applied on that edge and its effect is
// visible on all outputs immediately after it.
module nbit_demux_reg
  import nbit_demux_reg_pkg::*;
#(
  parameter int SELECT_WIDTH = DEFAULT_SELECT_WIDTH
) (
  input  logic                                clk,
  input  logic                                rst_n,
  input  logic                                DemuxIn,
  input  logic [SELECT_WIDTH-1:0]             DemuxSel,
  input  logic                                wr_en,
  input  logic                                shift_en,
  input  logic                                clear,
  output logic [word_width(SELECT_WIDTH)-1:0] DemuxOut,
  output logic [word_width(SELECT_WIDTH)-1:0] valid_mask,
  output logic [SELECT_WIDTH-1:0]             ptr,
  output logic                                full,
  output logic                                done,
  output demux_state_e                        dbg_state
);

  localparam int N = word_width(SELECT_WIDTH);

  logic [N-1:0] data_q, data_d;
  logic [N-1:0] mask_q, mask_d;
  demux_state_e state_q, state_d;
  logic         full_q, full_d;
  logic         done_q, done_d;

  ptr_counter #(.W(SELECT_WIDTH)) u_ptr (
    .clk   (clk),
    .rst_n (rst_n),
    .en    (shift_en),
    .clr   (clear),
    .count (ptr)
  );

  // Next data and mask. The random-access write is applied after the
  // sequential one so it wins when both target the same bit.
  always_comb begin
    data_d = data_q;
    mask_d = mask_q;
    if (clear) begin
      data_d = '0;
      mask_d = '0;
    end else begin
      if (shift_en) begin
        data_d[ptr] = DemuxIn;
        mask_d[ptr] = 1'b1;
      end
      if (wr_en) begin
        data_d[DemuxSel] = DemuxIn;
        mask_d[DemuxSel] = 1'b1;
      end
    end
  end

  // State is derived from the next mask so full/done land on the same edge
  // as the completing write. Leaving FULL requires a clear (mask -> 0), so
  // done cannot re-pulse while the word stays full.
  always_comb begin
    if (mask_d == '0) begin
      state_d = ST_EMPTY;
    end else if (&mask_d) begin
      state_d = ST_FULL;
    end else begin
      state_d = ST_PARTIAL;
    end
    full_d = (state_d == ST_FULL);
    done_d = (state_d == ST_FULL) && (state_q != ST_FULL);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      data_q  <= '0;
      mask_q  <= '0;
      state_q <= ST_EMPTY;
      full_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      data_q  <= data_d;
      mask_q  <= mask_d;
      state_q <= state_d;
      full_q  <= full_d;
      done_q  <= done_d;
    end
  end

  assign DemuxOut   = data_q;
  assign valid_mask = mask_q;
  assign full       = full_q;
  assign done       = done_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_nbit_demux_reg.sv
module tb_nbit_demux_reg;
  import nbit_demux_reg_pkg::*;

  localparam int SW = 3;
  localparam int N  = 8;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic          din = 1'b0;
  logic [SW-1:0] sel = '0;
  logic          wr_en = 1'b0;
  logic          shift_en = 1'b0;
  logic          clear = 1'b0;
  logic [N-1:0]  demux_out;
  logic [N-1:0]  valid_mask;
  logic [SW-1:0] ptr;
  logic          full;
  logic          done;
  demux_state_e  dbg_state;

  nbit_demux_reg #(.SELECT_WIDTH(SW)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .DemuxIn    (din),
    .DemuxSel   (sel),
    .wr_en      (wr_en),
    .shift_en   (shift_en),
    .clear      (clear),
    .DemuxOut   (demux_out),
    .valid_mask (valid_mask),
    .ptr        (ptr),
    .full       (full),
    .done       (done),
    .dbg_state  (dbg_state)
  );

  // ---------------- reference model ----------------
  // Word kept as arrays of bits plus a written-bit count; full/done follow
  // from whether all N bits have been written since the last clear.
  bit m_data [N];
  bit m_written [N];
  int m_ptr;
  bit m_full;
  bit m_done;

  int checks = 0;
  int errors = 0;

  function automatic void model_reset();
    for (int i = 0; i < N; i++) begin
      m_data[i] = 1'b0;
      m_written[i] = 1'b0;
    end
    m_ptr = 0;
    m_full = 1'b0;
    m_done = 1'b0;
  endfunction

  function automatic int written_count();
    int c = 0;
    for (int i = 0; i < N; i++) c += m_written[i];
    return c;
  endfunction

  function automatic void model_step(bit w, bit s, bit d, int idx, bit c);
    bit now_full;
    if (c) begin
      model_reset();
      return;
    end
    if (s) begin
      m_data[m_ptr] = d;
      m_written[m_ptr] = 1'b1;
    end
    if (w) begin
      m_data[idx] = d;
      m_written[idx] = 1'b1;
    end
    if (s) m_ptr = (m_ptr + 1) % N;
    now_full = (written_count() == N);
    m_done = now_full && !m_full;
    m_full = now_full;
  endfunction

  function automatic logic [31:0] pack_data();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_data[i];
    return v;
  endfunction

  function automatic logic [31:0] pack_mask();
    logic [31:0] v = '0;
    for (int i = 0; i < N; i++) v[i] = m_written[i];
    return v;
  endfunction

  function automatic logic [31:0] exp_state();
    int c = written_count();
    if (c == 0) return 32'd0;
    if (c == N) return 32'd2;
    return 32'd1;
  endfunction

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic check_all(input string tag);
    check({tag, ".out"},   32'(demux_out),  pack_data());
    check({tag, ".mask"},  32'(valid_mask), pack_mask());
    check({tag, ".ptr"},   32'(ptr),        32'(m_ptr));
    check({tag, ".full"},  32'(full),       32'(m_full));
    check({tag, ".done"},  32'(done),       32'(m_done));
    check({tag, ".state"}, 32'(dbg_state),  exp_state());
  endtask

  // ---------------- driver ----------------
  task automatic step(input string tag, input bit w, input bit s, input bit d,
                      input int idx, input bit c);
    @(negedge clk);
    wr_en = w; shift_en = s; din = d; sel = SW'(idx); clear = c;
    @(posedge clk);
    model_step(w, s, d, idx, c);
    #1;
    wr_en = 1'b0; shift_en = 1'b0; clear = 1'b0;
    check_all(tag);
  endtask

  task automatic idle(input string tag);
    step(tag, 1'b0, 1'b0, 1'b0, 0, 1'b0);
  endtask

  // ---------------- stimulus ----------------
  bit fill_seq [8] = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0};
  bit a5_low   [5] = '{1'b1, 1'b0, 1'b1, 1'b0, 1'b0};
  int done_seen;

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;

    // Build 8'hA5 with ptr=5, then reset asynchronously mid-cycle.
    for (int i = 0; i < 5; i++) step("a5_shift", 1'b0, 1'b1, a5_low[i], 0, 1'b0);
    step("a5_wr5", 1'b1, 1'b0, 1'b1, 5, 1'b0);
    step("a5_wr7", 1'b1, 1'b0, 1'b1, 7, 1'b0);
    check("a5_value", 32'(demux_out), 32'hA5);
    check("a5_ptr", 32'(ptr), 32'd5);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("async_rst");
    @(negedge clk);
    rst_n = 1'b1;
    idle("post_rst_hold");

    // Serial fill 1,0,1,1,0,0,1,0 -> 8'h4D, ptr wraps, single done.
    done_seen = 0;
    for (int i = 0; i < 8; i++) begin
      step("fill", 1'b0, 1'b1, fill_seq[i], 0, 1'b0);
      done_seen += done;
    end
    check("fill_value", 32'(demux_out), 32'h4D);
    check("fill_done_now", 32'(done), 32'd1);
    idle("fill_after");
    done_seen += done;
    check("fill_done_once", 32'(done_seen), 32'd1);

    // Overwrite in FULL: bit 2 cleared, stays full, no second done.
    step("full_ovw", 1'b1, 1'b0, 1'b0, 2, 1'b0);
    check("full_ovw_value", 32'(demux_out), 32'h49);
    idle("full_hold");

    // Random access 7 then 0 -> 8'h81, PARTIAL, ptr 0.
    step("clr1", 1'b0, 1'b0, 1'b0, 0, 1'b1);
    step("ra_sel7", 1'b1, 1'b0, 1'b1, 7, 1'b0);
    step("ra_sel0", 1'b1, 1'b0, 1'b1, 0, 1'b0);
    check("ra_value", 32'(demux_out), 32'h81);
    check("ra_state", 32'(dbg_state), 32'(ST_PARTIAL));

    // Dual writes: same index at ptr=3, then ptr=4 with sel=6.
    step("clr2", 1'b0, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 3; i++) step("pre_dual", 1'b0, 1'b1, 1'b0, 0, 1'b0);
    step("dual_same", 1'b1, 1'b1, 1'b1, 3, 1'b0);
    step("dual_diff", 1'b1, 1'b1, 1'b0, 6, 1'b0);
    check("dual_ptr", 32'(ptr), 32'd5);
    check("dual_bit3", 32'(demux_out[3]), 32'd1);

    // Clear together with the completing shift: no done.
    step("clr3", 1'b0, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 7; i++) step("pre_clrfill", 1'b0, 1'b1, 1'b1, 0, 1'b0);
    step("clr_fill", 1'b0, 1'b1, 1'b1, 0, 1'b1);
    idle("clr_fill_after");
    check("clr_fill_done", 32'(done), 32'd0);

    // Randomized traffic with occasional clears.
    for (int i = 0; i < 400; i++) begin
      step("rand",
           1'($urandom_range(0, 1)),
           1'($urandom_range(0, 2) != 0),
           1'($urandom_range(0, 1)),
           int'($urandom_range(0, N - 1)),
           1'($urandom_range(0, 24) == 0));
    end

    // Reset mid-fill: no residual done afterwards.
    step("clr4", 1'b0, 1'b0, 1'b0, 0, 1'b1);
    for (int i = 0; i < 7; i++) step("pre_rstfill", 1'b0, 1'b1, 1'b1, 0, 1'b0);
    #2;
    rst_n = 1'b0;
    #1;
    model_reset();
    check_all("rst_midfill");
    @(negedge clk);
    rst_n = 1'b1;
    idle("rst_midfill_after");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/nbit_demux_reg.md
# nbit_demux_reg

Registered 1-to-2^SELECT_WIDTH demultiplexer. It deposits a single input bit into a selected position of an internal 2^SELECT_WIDTH-bit register, either by explicit select (random access) or by an internal auto-incrementing pointer (serial-to-parallel fill). It is the write-side counterpart of `nbit_mux`: where the mux reads one bit out of a word, this block assembles a word one bit at a time. It also tracks which bits have been written and flags completion.

## Interface
- `SELECT_WIDTH`, default 3. Select width; word width is N = 2**SELECT_WIDTH.
- `clk`  in  1  Single clock; all state changes on the rising edge.
- `rst_n`  in  1  Asynchronous, active-low reset.
- `DemuxIn`  in  1  Data bit to deposit.
- `DemuxSel`  in  SELECT_WIDTH  Target bit index for random-access writes.
- `wr_en`  in  1  Random-access write strobe: writes `DemuxIn` to bit `DemuxSel`.
- `shift_en`  in  1  Sequential write strobe: writes `DemuxIn` to bit `ptr`, then advances `ptr`.
- `clear`  in  1  Synchronous clear of data, mask, pointer and state.
- `DemuxOut`  out  N  Assembled word.
- `valid_mask`  out  N  Bit i is 1 once bit i has been written since the last clear or reset.
- `ptr`  out  SELECT_WIDTH  Current sequential write pointer.
- `full`  out  1  Level; high while `valid_mask` is all ones.
- `done`  out  1  One-cycle pulse on the edge where `valid_mask` becomes all ones.

## Operation
- State machine, three states:
  - EMPTY: mask is 0.
  - PARTIAL: mask is nonzero and not all ones.
  - FULL: mask is all ones.
- State is a registered encoding of the mask. `full` is 1 exactly when state is FULL.
- Priority, highest first:
  1. `clear`: `DemuxOut`=0, `valid_mask`=0, `ptr`=0, state EMPTY, `done`=0. All other strobes in that cycle are ignored.
  2. `wr_en` and `shift_en` together:
     - Both writes apply, and both mask bits are set.
     - If `DemuxSel` == `ptr`, the `wr_en` data wins for that bit.
     - `ptr` still increments.
  3. A single strobe applies alone.
- `ptr` increments modulo N and wraps from N-1 to 0 with no flag or stall.
- Writes in FULL still update `DemuxOut`. The mask stays all ones and `done` does not re-pulse until a clear or reset has occurred.
- `done` is asserted in the cycle after the write that sets the last mask bit. This holds even if several bits complete in one cycle (dual write).
- Unwritten bits read as 0.
- No strobe active: all registers hold.

## Timing
- Reset (async assert, `rst_n`=0): `DemuxOut`=0, `valid_mask`=0, `ptr`=0, `full`=0, `done`=0, state EMPTY. Outputs update immediately on assertion, without waiting for a clock edge.
- Deassertion is synchronized externally. The first edge with `rst_n`=1 processes strobes normally.
- Write latency is 1 cycle: data, mask, `ptr`, `full` and `done` reflect a write on the edge that samples the strobe.
- `done` is high for exactly one cycle. `full` stays high until a clear or reset.
- Reset mid-fill discards partial data. No residual `done` pulse is produced.
- `clear` in the same cycle as the last fill write: the clear wins, `done` stays 0, state EMPTY.
- No combinational path from inputs to outputs; every output is a register.

## Structure
- Shared package/include: state encodings `ST_EMPTY`=2'd0, `ST_PARTIAL`=2'd1, `ST_FULL`=2'd2, plus a helper constant for the N = 2**SELECT_WIDTH derivation. The processor control FSMs reuse these.
- One natural sub-module, `ptr_counter`: a SELECT_WIDTH-bit wrapping counter with enable and synchronous clear. Everything else lives in the top module.

## Test plan
- Reset while holding `DemuxOut`=8'hA5 and `ptr`=5 → all outputs 0 immediately, before any clock edge. The next cycle with no strobes holds at 0.
- Eight `shift_en` cycles with `DemuxIn` sequence 1,0,1,1,0,0,1,0 (SELECT_WIDTH=3):
  - `DemuxOut`=8'h4D.
  - `ptr` wraps to 0.
  - `done` pulses once, one cycle after the 8th write.
  - `full`=1 thereafter.
- Random-access writes `wr_en` with Sel=7, `DemuxIn`=1 then Sel=0, `DemuxIn`=1 → `DemuxOut`=8'h81, `valid_mask`=8'h81, state PARTIAL, `ptr` unchanged at 0.
- Dual write with `ptr`=3, Sel=3 and `DemuxIn`=1, then `ptr`=4, Sel=6 and `DemuxIn`=0:
  - Bit 3 = 1; mask bits 3, 4 and 6 set.
  - `ptr` advances to 5 after the second cycle.
  - Same-index case confirms `wr_en` precedence.
- `clear` asserted together with the final `shift_en` that would fill the word → `done` never pulses, outputs 0, `ptr`=0.
- After FULL, overwrite Sel=2 with 0 → `DemuxOut` bit 2 clears, `full` stays 1, no second `done` pulse.
